// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 register numbers, exception codes, field positions and
// the controller's state/event types.
package exc_ctrl_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_BEV   = 22;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IE    = 0;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_EXC_LO = 2;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic {IDLE, REDIRECT} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_INT, EV_EXC, EV_ERET} event_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// M-stage exception/CP0 bundle between the pipeline (master) and the
// exception controller (slave).
interface exc_ctrl_if;
    logic        valid_M;
    logic [4:0]  exc_M;
    logic        adel_if_M;
    logic [31:0] pc_M;
    logic        bd_M;
    logic [31:0] badvaddr_M;
    logic        eret_M;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exl;

    modport master (
        output valid_M, exc_M, adel_if_M, pc_M, bd_M, badvaddr_M, eret_M,
        output mtc0_we, cp0_addr, cp0_wdata, hw_int,
        input  cp0_rdata, flush, redirect_valid, redirect_pc, exl
    );

    modport slave (
        input  valid_M, exc_M, adel_if_M, pc_M, bd_M, badvaddr_M, eret_M,
        input  mtc0_we, cp0_addr, cp0_wdata, hw_int,
        output cp0_rdata, flush, redirect_valid, redirect_pc, exl
    );
endinterface

// File: rtl/exc_ctrl_cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second clock, TI latches
// on a Count==Compare match and is cleared by a Compare write.
module exc_ctrl_cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic toggle;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count   <= '0;
            compare <= '0;
            toggle  <= 1'b0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count  <= wdata;
                toggle <= 1'b0;
            end else begin
                toggle <= ~toggle;
                if (toggle)
                    count <= count + 32'd1;
            end
            // A Compare of zero disarms the timer match.
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare && compare != '0) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-boundary exception/CP0 controller: takes interrupts, exceptions and
// ERET, keeps CP0 state and sequences a two-cycle flush/redirect.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input logic        clk,
    input logic        resetn,
    exc_ctrl_if.slave  bus
);

    state_t      state;
    event_t      ev;
    logic [7:0]  im;
    logic        st_exl;
    logic        ie;
    logic        cause_bd;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] target;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [7:0]  ip;
    logic        int_pend;
    logic        mtc0_ok;

    assign ip       = {bus.hw_int[5] | ti, bus.hw_int[4:0], ip_sw};
    assign int_pend = (|(ip & im)) & ie & ~st_exl;

    always_comb begin
        ev = EV_NONE;
        if (resetn && state == IDLE && bus.valid_M) begin
            if (int_pend)
                ev = EV_INT;
            else if (bus.exc_M != EXC_INT)
                ev = EV_EXC;
            else if (bus.eret_M)
                ev = EV_ERET;
        end
    end

    // An MTC0 in a flushed or event cycle never commits.
    assign mtc0_ok = bus.mtc0_we && state == IDLE && ev == EV_NONE;

    exc_ctrl_cp0_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (mtc0_ok && bus.cp0_addr == CP0_COUNT),
        .compare_we (mtc0_ok && bus.cp0_addr == CP0_COMPARE),
        .wdata      (bus.cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            im       <= STATUS_RESET[15:8];
            st_exl   <= STATUS_RESET[STATUS_EXL];
            ie       <= STATUS_RESET[STATUS_IE];
            cause_bd <= 1'b0;
            ip_sw    <= 2'b00;
            exc_code <= EXC_INT;
            epc      <= '0;
            badvaddr <= '0;
            target   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    case (ev)
                        EV_INT, EV_EXC: begin
                            exc_code <= (ev == EV_INT) ? EXC_INT : bus.exc_M;
                            if (!st_exl) begin
                                epc      <= bus.bd_M ? bus.pc_M - 32'd4 : bus.pc_M;
                                cause_bd <= bus.bd_M;
                            end
                            st_exl <= 1'b1;
                            if (ev == EV_EXC && bus.exc_M == EXC_ADEL && bus.adel_if_M)
                                badvaddr <= bus.pc_M;
                            else if (ev == EV_EXC && (bus.exc_M == EXC_ADEL || bus.exc_M == EXC_ADES))
                                badvaddr <= bus.badvaddr_M;
                            target <= EXC_VECTOR;
                            state  <= REDIRECT;
                        end
                        EV_ERET: begin
                            st_exl <= 1'b0;
                            target <= epc;
                            state  <= REDIRECT;
                        end
                        default: begin
                            if (mtc0_ok) begin
                                case (bus.cp0_addr)
                                    CP0_STATUS: begin
                                        im     <= bus.cp0_wdata[15:8];
                                        st_exl <= bus.cp0_wdata[STATUS_EXL];
                                        ie     <= bus.cp0_wdata[STATUS_IE];
                                    end
                                    CP0_CAUSE: ip_sw <= bus.cp0_wdata[9:8];
                                    CP0_EPC:   epc   <= bus.cp0_wdata;
                                    default: ;
                                endcase
                            end
                        end
                    endcase
                end
                REDIRECT: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.cp0_rdata = '0;
        case (bus.cp0_addr)
            CP0_BADVADDR: bus.cp0_rdata = badvaddr;
            CP0_COUNT:    bus.cp0_rdata = count;
            CP0_COMPARE:  bus.cp0_rdata = compare;
            CP0_STATUS: begin
                bus.cp0_rdata[STATUS_BEV]                    = 1'b1;
                bus.cp0_rdata[STATUS_IM_LO +: 8]             = im;
                bus.cp0_rdata[STATUS_EXL]                    = st_exl;
                bus.cp0_rdata[STATUS_IE]                     = ie;
            end
            CP0_CAUSE: begin
                bus.cp0_rdata[CAUSE_BD]                      = cause_bd;
                bus.cp0_rdata[CAUSE_TI]                      = ti;
                bus.cp0_rdata[CAUSE_IP_LO +: 8]              = ip;
                bus.cp0_rdata[CAUSE_EXC_LO +: 5]             = exc_code;
            end
            CP0_EPC:      bus.cp0_rdata = epc;
            default: ;
        endcase
    end

    assign bus.flush          = (ev != EV_NONE) || state == REDIRECT;
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = (state == REDIRECT) ? target : '0;
    assign bus.exl            = st_exl;

endmodule
